// File: rtl/wdt_pkg.sv
// Shared encodings for the window-watchdog supervisor: FSM state codes
// and per-channel violation classification.
package wdt_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ARMED = 3'd1;
    localparam logic [STATE_W-1:0] WARN  = 3'd2;
    localparam logic [STATE_W-1:0] RESET = 3'd3;
    localparam logic [STATE_W-1:0] FAULT = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = IDLE,
        ST_ARMED = ARMED,
        ST_WARN  = WARN,
        ST_RESET = RESET,
        ST_FAULT = FAULT
    } state_t;

    typedef enum logic [1:0] {
        VIOL_NONE  = 2'd0,
        VIOL_EARLY = 2'd1,
        VIOL_LATE  = 2'd2
    } viol_t;

endpackage

// File: rtl/wdt_window_channel.sv
// One windowed kick counter: counts while running and enabled, saturates at
// COUNT, and classifies each cycle as valid kick, early kick or late timeout.
module wdt_window_channel
    import wdt_pkg::*;
#(
    parameter int LENGTH    = 5,
    parameter int COUNT     = 20,
    parameter int THRESHOLD = 10
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  run,
    input  logic  en,
    input  logic  kick,
    input  logic  clr,
    output viol_t viol,
    output logic  valid
);

    logic [LENGTH-1:0] cnt;
    logic [LENGTH-1:0] cnt_next;
    logic              active;
    logic              at_limit;
    logic              in_window;

    always_comb begin
        active    = run & en;
        at_limit  = (cnt == LENGTH'(COUNT));
        in_window = (cnt >= LENGTH'(THRESHOLD));
        valid     = active & kick & in_window;

        viol = VIOL_NONE;
        if (active && kick && !in_window) begin
            viol = VIOL_EARLY;
        end else if (active && !kick && at_limit) begin
            viol = VIOL_LATE;
        end

        // clr is the supervisor's recovery kick: restart regardless of window
        cnt_next = cnt;
        if (!active || clr || valid) begin
            cnt_next = '0;
        end else if (!at_limit) begin
            cnt_next = cnt + LENGTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/wdt_supervisor.sv
// Multi-channel window watchdog: escalates violations through WARN (grace),
// bounded RESET retries, then a latched FAULT cleared by clear_fault.
module wdt_supervisor
    import wdt_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int LENGTH    = 5,
    parameter int COUNT     = 20,
    parameter int THRESHOLD = 10,
    parameter int GRACE     = 8,
    parameter int RST_LEN   = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [NCH-1:0]     ch_en,
    input  logic [NCH-1:0]     kick,
    input  logic               clear_fault,
    output logic               irq,
    output logic [NCH-1:0]     timeout_ch,
    output logic               rst_req,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [1:0]         retry_cnt
);

    localparam int GW = (GRACE > 1) ? $clog2(GRACE) : 1;
    localparam int RW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

    state_t         cur;
    state_t         nxt;
    logic [GW-1:0]  grace;
    logic [GW-1:0]  grace_next;
    logic [RW-1:0]  rcnt;
    logic [RW-1:0]  rcnt_next;
    logic [1:0]     retry_next;
    logic [NCH-1:0] tc_next;
    logic [NCH-1:0] seen;
    logic [NCH-1:0] seen_next;
    logic [NCH-1:0] viol_vec;
    logic [NCH-1:0] valid_vec;
    logic [NCH-1:0] flag_kick;
    viol_t          viol [NCH];
    logic           run;

    assign run       = (cur == ST_ARMED) || (cur == ST_WARN);
    assign flag_kick = (cur == ST_WARN) ? (kick & ch_en & timeout_ch) : '0;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        wdt_window_channel #(
            .LENGTH   (LENGTH),
            .COUNT    (COUNT),
            .THRESHOLD(THRESHOLD)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .run    (run),
            .en     (ch_en[i]),
            .kick   (kick[i]),
            .clr    (flag_kick[i]),
            .viol   (viol[i]),
            .valid  (valid_vec[i])
        );
        assign viol_vec[i] = (viol[i] != VIOL_NONE);
    end

    always_comb begin
        nxt        = cur;
        tc_next    = timeout_ch;
        grace_next = grace;
        rcnt_next  = rcnt;
        retry_next = retry_cnt;
        seen_next  = seen;

        case (cur)
            ST_IDLE: begin
                seen_next = '0;
                if (enable) nxt = ST_ARMED;
            end
            ST_ARMED, ST_WARN: begin
                // A recovery kick on a flagged channel masks its own early report
                tc_next   = (timeout_ch | viol_vec) & ~flag_kick;
                seen_next = seen | (valid_vec & ch_en);
                if (cur == ST_ARMED) begin
                    if ((seen_next & ch_en) == ch_en) retry_next = '0;
                    if (tc_next != '0) begin
                        nxt        = ST_WARN;
                        grace_next = '0;
                    end
                end else if (tc_next == '0) begin
                    nxt = ST_ARMED;
                end else if (grace == GW'(GRACE - 1)) begin
                    nxt        = ST_RESET;
                    rcnt_next  = '0;
                    retry_next = retry_cnt + 2'd1;
                end else begin
                    grace_next = grace + GW'(1);
                end
            end
            ST_RESET: begin
                if (rcnt == RW'(RST_LEN - 1)) begin
                    tc_next   = '0;
                    seen_next = '0;
                    nxt       = (retry_cnt == 2'(MAX_RETRY)) ? ST_FAULT : ST_ARMED;
                end else begin
                    rcnt_next = rcnt + RW'(1);
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    nxt        = ST_IDLE;
                    retry_next = '0;
                end
            end
            default: nxt = ST_IDLE;
        endcase

        // Dropping enable abandons any escalation except a latched fault
        if (!enable && (cur == ST_ARMED || cur == ST_WARN || cur == ST_RESET)) begin
            nxt        = ST_IDLE;
            tc_next    = '0;
            retry_next = '0;
            seen_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur        <= ST_IDLE;
            timeout_ch <= '0;
            grace      <= '0;
            rcnt       <= '0;
            retry_cnt  <= '0;
            seen       <= '0;
        end else begin
            cur        <= nxt;
            timeout_ch <= tc_next;
            grace      <= grace_next;
            rcnt       <= rcnt_next;
            retry_cnt  <= retry_next;
            seen       <= seen_next;
        end
    end

    assign state   = cur;
    assign irq     = (cur == ST_WARN);
    assign rst_req = (cur == ST_RESET) || (cur == ST_FAULT);
    assign fault   = (cur == ST_FAULT);

endmodule

// File: doc/wdt_supervisor.md
Name: wdt_supervisor

Overview:
Multi-channel window-watchdog supervisor. It owns NCH windowed kick counters, one per monitored subsystem, and detects late (timeout) and early (window violation) kicks. It escalates violations through a warning/grace period, then a bounded number of subsystem reset pulses, then a latched fault. It sits between the monitored engines and the system reset/interrupt controller.

Parameters:
NCH, 4, number of monitored channels
LENGTH, 5, counter width in bits; COUNT must fit in LENGTH bits
COUNT, 20, late limit: counter value at which an unkicked channel times out
THRESHOLD, 10, window opening: a kick with counter < THRESHOLD is an early violation; THRESHOLD < COUNT
GRACE, 8, cycles allowed in WARN for recovery kicks
RST_LEN, 4, cycles rst_req is asserted per retry
MAX_RETRY, 3, consecutive reset retries before FAULT; must fit in 2 bits

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  supervisor enable; level-sensitive
ch_en  in  NCH  per-channel enable
kick  in  NCH  per-channel kick, one-cycle pulse
clear_fault  in  1  pulse; exits FAULT
irq  out  1  warning interrupt, high in WARN
timeout_ch  out  NCH  violating-channel mask
rst_req  out  1  subsystem reset request
fault  out  1  latched fault
state  out  3  current FSM state
retry_cnt  out  2  consecutive retries taken

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all counters 0, irq=0, timeout_ch=0, rst_req=0, fault=0, retry_cnt=0. Effect is immediate and independent of clk.
- Channel counter, only in ARMED or WARN with ch_en[i]=1:
  - Counter is 0 in the first ARMED cycle and increments by 1 per cycle.
  - A kick with THRESHOLD <= cnt <= COUNT is valid: cnt becomes 0 next cycle.
  - A kick with cnt < THRESHOLD is an early violation.
  - cnt == COUNT with no kick is a late violation.
  - The counter saturates at COUNT and never wraps.
- Kick and COUNT in the same cycle: the kick is valid and no violation occurs.
- Disabled channel (ch_en[i]=0): counter held at 0, kick ignored, never violates. A newly enabled channel starts from 0.
- FSM encoding: IDLE=0, ARMED=1, WARN=2, RESET=3, FAULT=4.
- IDLE: all outputs 0, counters 0. enable=1 moves to ARMED on the next edge.
- ARMED: any enabled-channel violation moves to WARN on the next edge; the violating bits are OR'd into timeout_ch and the grace counter is loaded with 0.
- WARN:
  - irq=1.
  - Any kick on a flagged channel clears its timeout_ch bit and resets its counter; the window is not checked.
  - New violations on other channels add their bits.
  - timeout_ch==0 returns to ARMED next edge, with irq=0 there.
  - If the grace counter reaches GRACE-1 with bits still set, go to RESET.
- RESET:
  - rst_req=1 for exactly RST_LEN cycles; counters held at 0; retry_cnt increments on entry.
  - Exit goes to FAULT if retry_cnt==MAX_RETRY, otherwise to ARMED. In both cases timeout_ch clears.
- retry_cnt clears in ARMED once every enabled channel has made a valid kick since the last RESET exit; tracked with an NCH-bit seen mask.
- FAULT: fault=1, rst_req=1, irq=0. enable is ignored. clear_fault moves to IDLE and clears retry_cnt, fault and rst_req.
- enable=0 in ARMED, WARN or RESET: IDLE on the next edge. rst_req drops immediately with the state change; timeout_ch and retry_cnt clear.
- All outputs are registered or decoded from registered state. Kick-to-effect latency is 1 cycle.

Decomposition:
- Package wdt_pkg holds:
  - state localparams (IDLE..FAULT) and the 3-bit state width;
  - a violation-type encoding (NONE, EARLY, LATE).
- Sub-module wdt_window_channel (one instance per channel, via generate) contains:
  - the counter, window compare and violation output;
  - inputs: clk, reset_n, run, en, kick, clr.
- The FSM, grace/reset counters and retry logic stay in wdt_supervisor.

Test Plan:
- ch_en=0001, enable=1, kick ch0 every 15 cycles for 200 cycles -> state stays 1, irq=0, timeout_ch=0000.
- ch_en=0011, kick ch0 only -> 21 cycles after ARMED entry: state=2, timeout_ch=0010, irq=1; kick ch1 3 cycles later -> state=1, irq=0 on the next edge.
- Kick ch0 at cnt=5 -> WARN with timeout_ch=0001. Separately, kick exactly at cnt=20 -> valid, no WARN.
- No recovery -> WARN lasts 8 cycles, then rst_req=1 for 4 cycles and retry_cnt=1. Repeat -> after the 3rd RESET: state=4, fault=1, rst_req=1. Then clear_fault -> state=0, retry_cnt=0, all outputs 0.
- After 1 retry, kick all enabled channels validly -> retry_cnt returns to 0.
- Assert reset_n=0 mid-RESET (rst_req=1) -> rst_req, irq and state drop to 0 before the next clk edge.
- enable=0 during WARN -> IDLE on the next edge, timeout_ch=0.
